// File: rtl/jpeg_pkg.sv
// Shared types for the JPEG front end.
// Pixel format and 8x8 block geometry.
package jpeg_pkg;

  typedef logic [23:0] ycbcr_pixel_t;

  localparam int BLOCK_N   = 8;
  localparam int BLOCK_PIX = BLOCK_N * BLOCK_N;

  typedef struct packed {
    logic first;
    logic last;
    logic stripe_last;
  } blk_tag_t;

endpackage

// File: rtl/bb_dp_ram.sv
// Simple dual-port RAM, one write and one registered read port.
// Read data holds when re_i is low.
module bb_dp_ram #(
  parameter int DW = 24,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we_i)
      mem_q[waddr_i] <= wdata_i;
    if (re_i)
      rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/raster_to_block_buffer.sv
// Raster to 8x8 block reorder buffer.
// Ping-pong stripe banks, valid/ready output.
module raster_to_block_buffer
  import jpeg_pkg::*;
#(
  parameter int IMG_WIDTH = 64,
  parameter int DATA_W    = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_block_first,
  output logic              out_block_last,
  output logic              overflow
);

  localparam int STRIPE = BLOCK_N * IMG_WIDTH;
  localparam int AW     = $clog2(STRIPE);
  localparam int NBLK   = IMG_WIDTH / BLOCK_N;
  localparam int BW     = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam int RW     = $clog2(BLOCK_N);

  localparam logic [AW-1:0] W_LAST = AW'(STRIPE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(NBLK - 1);
  localparam logic [RW-1:0] R_LAST = RW'(BLOCK_N - 1);

  logic              wbank_q, wbank_d;
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [1:0]        full_q, full_d;
  logic              ibank_q, ibank_d;
  logic              rbank_q, rbank_d;
  logic [BW-1:0]     rblk_q, rblk_d;
  logic [RW-1:0]     rrow_q, rrow_d;
  logic [RW-1:0]     rk_q, rk_d;
  logic              p1_vld_q, p1_vld_d;
  blk_tag_t          p1_tag_q, p1_tag_d;
  logic              o_vld_q, o_vld_d;
  blk_tag_t          o_tag_q, o_tag_d;
  logic [DATA_W-1:0] o_data_q, o_data_d;
  logic              ovf_q, ovf_d;

  logic              wr_en, wr_last;
  logic              adv, issue, xfer, clr;
  logic [AW-1:0]     roff;
  blk_tag_t          rd_tag;
  logic [DATA_W-1:0] ram_rdata;

  always_comb begin
    wr_en   = in_valid && !full_q[wbank_q];
    wr_last = wr_en && (wptr_q == W_LAST);
    adv     = !o_vld_q || out_ready;
    issue   = full_q[ibank_q] && (!p1_vld_q || adv);
    xfer    = o_vld_q && out_ready;
    clr     = xfer && o_tag_q.stripe_last;
    roff    = AW'(rrow_q) * AW'(IMG_WIDTH)
            + AW'(rblk_q) * AW'(BLOCK_N)
            + AW'(rk_q);
    rd_tag.first       = (rrow_q == '0) && (rk_q == '0);
    rd_tag.last        = (rrow_q == R_LAST) && (rk_q == R_LAST);
    rd_tag.stripe_last = rd_tag.last && (rblk_q == B_LAST);
  end

  always_comb begin
    wbank_d  = wbank_q;
    wptr_d   = wptr_q;
    full_d   = full_q;
    ibank_d  = ibank_q;
    rbank_d  = rbank_q;
    rblk_d   = rblk_q;
    rrow_d   = rrow_q;
    rk_d     = rk_q;
    p1_vld_d = p1_vld_q;
    p1_tag_d = p1_tag_q;
    o_vld_d  = o_vld_q;
    o_tag_d  = o_tag_q;
    o_data_d = o_data_q;
    ovf_d    = ovf_q | (in_valid && full_q[wbank_q]);

    if (wr_en) begin
      wptr_d = wr_last ? '0 : wptr_q + 1'b1;
      if (wr_last) begin
        wbank_d         = ~wbank_q;
        full_d[wbank_q] = 1'b1;
      end
    end
    // full is cleared only once the last pixel has left the output register
    if (clr) begin
      full_d[rbank_q] = 1'b0;
      rbank_d         = ~rbank_q;
    end

    if (issue) begin
      p1_vld_d = 1'b1;
      p1_tag_d = rd_tag;
      if (rk_q == R_LAST) begin
        rk_d = '0;
        if (rrow_q == R_LAST) begin
          rrow_d = '0;
          if (rblk_q == B_LAST) begin
            rblk_d  = '0;
            ibank_d = ~ibank_q;
          end else begin
            rblk_d = rblk_q + 1'b1;
          end
        end else begin
          rrow_d = rrow_q + 1'b1;
        end
      end else begin
        rk_d = rk_q + 1'b1;
      end
    end else if (adv) begin
      p1_vld_d = 1'b0;
    end

    if (adv) begin
      o_vld_d = p1_vld_q;
      o_tag_d = p1_vld_q ? p1_tag_q : '0;
      if (p1_vld_q)
        o_data_d = ram_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbank_q  <= 1'b0;
      wptr_q   <= '0;
      full_q   <= '0;
      ibank_q  <= 1'b0;
      rbank_q  <= 1'b0;
      rblk_q   <= '0;
      rrow_q   <= '0;
      rk_q     <= '0;
      p1_vld_q <= 1'b0;
      p1_tag_q <= '0;
      o_vld_q  <= 1'b0;
      o_tag_q  <= '0;
      o_data_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wbank_q  <= wbank_d;
      wptr_q   <= wptr_d;
      full_q   <= full_d;
      ibank_q  <= ibank_d;
      rbank_q  <= rbank_d;
      rblk_q   <= rblk_d;
      rrow_q   <= rrow_d;
      rk_q     <= rk_d;
      p1_vld_q <= p1_vld_d;
      p1_tag_q <= p1_tag_d;
      o_vld_q  <= o_vld_d;
      o_tag_q  <= o_tag_d;
      o_data_q <= o_data_d;
      ovf_q    <= ovf_d;
    end
  end

  // depth rounded to a power of two so the MSB alone selects the bank
  bb_dp_ram #(
    .DW (DATA_W),
    .AW (AW + 1)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i ({wbank_q, wptr_q}),
    .wdata_i (in_data),
    .re_i    (issue),
    .raddr_i ({ibank_q, roff}),
    .rdata_o (ram_rdata)
  );

  assign out_valid       = o_vld_q;
  assign out_data        = o_data_q;
  assign out_block_first = o_tag_q.first;
  assign out_block_last  = o_tag_q.last;
  assign overflow        = ovf_q;

endmodule

// File: tb/tb_raster_to_block_buffer.sv
// Randomized bench for raster_to_block_buffer.
// Stripe-level reference model with expected-output queue.
module tb_raster_to_block_buffer;
  import jpeg_pkg::*;

  localparam int W      = 16;
  localparam int STRIPE = BLOCK_N * W;
  localparam int NB     = W / BLOCK_N;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  ycbcr_pixel_t in_data = '0;
  logic         out_ready = 1'b0;
  logic         out_valid;
  ycbcr_pixel_t out_data;
  logic         out_block_first;
  logic         out_block_last;
  logic         overflow;

  raster_to_block_buffer #(
    .IMG_WIDTH (W),
    .DATA_W    (24)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .out_ready       (out_ready),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .out_block_first (out_block_first),
    .out_block_last  (out_block_last),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    ycbcr_pixel_t d;
    logic         f;
    logic         l;
  } exp_t;

  exp_t         exp_q[$];
  ycbcr_pixel_t sbuf [STRIPE];
  int           n_in = 0;
  int           pend = 0;
  int           pend_old = 0;
  int           out_cnt = 0;
  int           cyc = 0;
  int           lat_edge = 0;
  int           checks = 0;
  int           failures = 0;
  int           rdy_mode = 0;
  logic         rdy_hold = 1'b1;
  logic         exp_ovf = 1'b0;
  logic         stall_prev = 1'b0;
  logic         lat_arm = 1'b0;
  logic         gap_en = 1'b0;
  logic         seen = 1'b0;
  logic         rst_chk = 1'b1;
  ycbcr_pixel_t prev_data = '0;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // block order derived from the addressing rule, one full stripe at a time
  task automatic push_stripe();
    for (int b = 0; b < NB; b++)
      for (int r = 0; r < BLOCK_N; r++)
        for (int k = 0; k < BLOCK_N; k++) begin
          exp_t e;
          e.d = sbuf[r * W + b * BLOCK_N + k];
          e.f = (r == 0) && (k == 0);
          e.l = (r == BLOCK_N - 1) && (k == BLOCK_N - 1);
          exp_q.push_back(e);
        end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       out_ready = ~out_ready;
      2:       out_ready = ($urandom_range(0, 99) < 60);
      default: out_ready = rdy_hold;
    endcase
  end

  always @(negedge clk) begin
    if (rst) begin
      if (rst_chk) begin
        check_eq("rst_valid", 32'(out_valid), 0);
        check_eq("rst_data", 32'(out_data), 0);
        check_eq("rst_first", 32'(out_block_first), 0);
        check_eq("rst_last", 32'(out_block_last), 0);
        check_eq("rst_ovf", 32'(overflow), 0);
        rst_chk = 1'b0;
      end
      exp_q.delete();
      n_in = 0; pend = 0; out_cnt = 0;
      exp_ovf = 1'b0; stall_prev = 1'b0;
      lat_arm = 1'b0; seen = 1'b0;
    end else begin
      pend_old = pend;
      check_eq("overflow", 32'(overflow), 32'(exp_ovf));
      if (stall_prev) begin
        check_eq("stall_valid", 32'(out_valid), 1);
        check_eq("stall_data", 32'(out_data), 32'(prev_data));
      end
      if (gap_en && seen && exp_q.size() > 0)
        check_eq("no_gap", 32'(out_valid), 1);
      if (out_valid) begin
        seen = 1'b1;
        if (lat_arm) begin
          check_eq("latency", 32'(cyc - lat_edge), 2);
          lat_arm = 1'b0;
        end
        if (exp_q.size() == 0) begin
          check_eq("spurious_valid", 32'(out_valid), 0);
        end else begin
          check_eq("data", 32'(out_data), 32'(exp_q[0].d));
          check_eq("first", 32'(out_block_first), 32'(exp_q[0].f));
          check_eq("last", 32'(out_block_last), 32'(exp_q[0].l));
          if (out_ready) begin
            void'(exp_q.pop_front());
            out_cnt++;
            if (out_cnt % STRIPE == 0) pend--;
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      if (in_valid) begin
        if (pend_old == 2) begin
          exp_ovf = 1'b1;
        end else begin
          sbuf[n_in] = in_data;
          n_in++;
          if (n_in == STRIPE) begin
            n_in = 0;
            if (pend_old == 0 && !out_valid) begin
              lat_arm  = 1'b1;
              lat_edge = cyc + 1;
            end
            push_stripe();
            pend++;
          end
        end
      end
    end
  end

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(ycbcr_pixel_t d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_stripe(int base);
    for (int i = 0; i < STRIPE; i++)
      send({16'h0000, 8'(base + i)});
  endtask

  task automatic drain(int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= budget)
      check_eq("drain_timeout", 32'(exp_q.size()), 0);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    send_stripe(0);
    drain(1000);

    rdy_mode = 1;
    send_stripe(0);
    drain(1000);
    rdy_mode = 0;

    gap_en = 1'b1;
    seen   = 1'b0;
    for (int s = 0; s < 3; s++)
      send_stripe(s * STRIPE);
    drain(1000);
    gap_en = 1'b0;

    rdy_hold = 1'b0;
    idle(2);
    send_stripe(0);
    send_stripe(STRIPE);
    idle(5);
    send(24'h0000aa);
    idle(3);
    check_eq("ovf_sticky", 32'(overflow), 1);
    rdy_hold = 1'b1;
    drain(2000);

    send_stripe(0);
    for (int i = 0; i < 50; i++)
      send({16'h0000, 8'(STRIPE + i)});
    rst     = 1'b1;
    rst_chk = 1'b1;
    idle(2);
    rst = 1'b0;
    send_stripe(0);
    drain(1000);

    rdy_mode = 2;
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 9) < 7)
        send(ycbcr_pixel_t'($urandom));
      else
        idle(1);
    end
    rdy_mode = 0;
    rdy_hold = 1'b1;
    drain(3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
